// File: rtl/adc_frontend_mc.sv
// ============================================================================
// Module   : adc_frontend_mc
// Brief    : N-channel offset-binary ADC front end: offset trim with clamp,
//            two's-complement conversion, optional boxcar average/decimate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_frontend_mc #(
   parameter int N_CH     = 2,
   parameter int ADC_W    = 12,
   parameter int OUT_W    = 16,
   parameter int AVG_LOG2 = 2,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    ad_clk,
   input  logic                    rst_n,
   input  logic [N_CH*ADC_W-1:0]   ad_in,
   input  logic                    offset_wr_en,
   input  logic [CH_W-1:0]         offset_wr_ch,
   input  logic [ADC_W-1:0]        offset_wr_data,
   input  logic                    avg_en,
   output logic [N_CH*OUT_W-1:0]   volt_out,
   output logic                    volt_valid,
   output logic [N_CH-1:0]         sat_flag
);

   localparam int                  ACC_W     = OUT_W + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] C_CNT_MAX = '1;
   localparam logic [0:0]          S_BYPASS  = 1'b0;
   localparam logic [0:0]          S_ACCUM   = 1'b1;

   logic [0:0]          r_state, w_state_nxt;
   logic [1:0]          r_pv;
   logic [AVG_LOG2-1:0] r_cnt;
   logic                w_bypass_out, w_accum, w_complete, w_clear;

   // r_pv covers S1/S2; the registered volt_valid acts as the third stage
   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_BYPASS;
         r_pv    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pv    <= {r_pv[0], 1'b1};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BYPASS: if (avg_en)  w_state_nxt = S_ACCUM;
         S_ACCUM:  if (!avg_en) w_state_nxt = S_BYPASS;
         default:  w_state_nxt = S_BYPASS;
      endcase
   end

   always_comb begin
      w_bypass_out = 1'b0;
      w_accum      = 1'b0;
      w_clear      = 1'b1;
      if (r_state == S_ACCUM && avg_en) begin
         w_accum = r_pv[1];
         w_clear = 1'b0;
      end else if (r_state == S_BYPASS) begin
         w_bypass_out = r_pv[1];
      end
      w_complete = w_accum && (r_cnt == C_CNT_MAX);
   end

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         volt_valid <= 1'b0;
      end else begin
         volt_valid <= w_bypass_out | w_complete;
         if (w_clear || w_complete)
            r_cnt <= '0;
         else if (w_accum)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [ADC_W-1:0]        r_off, r_raw, r_clamp, w_clamp;
      logic [ADC_W+1:0]        w_sum;
      logic                    r_sat, w_clip, r_sticky, r_flag;
      logic signed [OUT_W-1:0] w_smp, r_out;
      logic signed [ACC_W-1:0] r_acc, w_acc_sum;

      always_comb begin
         w_sum  = {2'b00, r_raw} + {{2{r_off[ADC_W-1]}}, r_off};
         w_clip = 1'b1;
         if (w_sum[ADC_W+1])
            w_clamp = '0;
         else if (w_sum[ADC_W])
            w_clamp = '1;
         else begin
            w_clamp = w_sum[ADC_W-1:0];
            w_clip  = 1'b0;
         end
      end

      // Subtracting mid-scale from an offset-binary code is an MSB flip
      assign w_smp     = {{(OUT_W-ADC_W+1){~r_clamp[ADC_W-1]}}, r_clamp[ADC_W-2:0]};
      assign w_acc_sum = r_acc + {{AVG_LOG2{w_smp[OUT_W-1]}}, w_smp};

      always_ff @(posedge ad_clk or negedge rst_n) begin
         if (!rst_n) begin
            r_off    <= '0;
            r_raw    <= '0;
            r_clamp  <= '0;
            r_sat    <= 1'b0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_out    <= '0;
            r_flag   <= 1'b0;
         end else begin
            if (offset_wr_en && offset_wr_ch == CH_W'(k))
               r_off <= offset_wr_data;
            r_raw   <= ad_in[k*ADC_W +: ADC_W];
            r_clamp <= w_clamp;
            r_sat   <= w_clip;
            if (w_clear || w_complete) begin
               r_acc    <= '0;
               r_sticky <= 1'b0;
            end else if (w_accum) begin
               r_acc    <= w_acc_sum;
               r_sticky <= r_sticky | r_sat;
            end
            if (w_bypass_out) begin
               r_out  <= w_smp;
               r_flag <= r_sat;
            end else if (w_complete) begin
               r_out  <= w_acc_sum[ACC_W-1:AVG_LOG2];
               r_flag <= r_sticky | r_sat;
            end
         end
      end

      assign volt_out[k*OUT_W +: OUT_W] = r_out;
      assign sat_flag[k]                = r_flag;
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_frontend_mc.sv
// ============================================================================
// Module   : tb_adc_frontend_mc
// Brief    : Directed self-checking bench for adc_frontend_mc (2 ch, 12 bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_frontend_mc;

   localparam int N_CH = 2;
   localparam int ADC_W = 12;
   localparam int OUT_W = 16;

   logic                  clk;
   logic                  rst_n;
   logic [N_CH*ADC_W-1:0] ad_in;
   logic                  offset_wr_en;
   logic [0:0]            offset_wr_ch;
   logic [ADC_W-1:0]      offset_wr_data;
   logic                  avg_en;
   logic [N_CH*OUT_W-1:0] volt_out;
   logic                  volt_valid;
   logic [N_CH-1:0]       sat_flag;

   logic signed [OUT_W-1:0] v0, v1;
   assign v0 = volt_out[OUT_W-1:0];
   assign v1 = volt_out[2*OUT_W-1:OUT_W];

   int n_cmp  = 0;
   int n_fail = 0;

   adc_frontend_mc #(.N_CH(N_CH), .ADC_W(ADC_W), .OUT_W(OUT_W), .AVG_LOG2(2)) dut (
      .ad_clk         (clk),
      .rst_n          (rst_n),
      .ad_in          (ad_in),
      .offset_wr_en   (offset_wr_en),
      .offset_wr_ch   (offset_wr_ch),
      .offset_wr_data (offset_wr_data),
      .avg_en         (avg_en),
      .volt_out       (volt_out),
      .volt_valid     (volt_valid),
      .sat_flag       (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   task automatic set_in(input int c0, input int c1);
      ad_in = {12'(c1), 12'(c0)};
   endtask

   task automatic wr_off(input int ch, input int data);
      offset_wr_en   = 1'b1;
      offset_wr_ch   = 1'(ch);
      offset_wr_data = 12'(data);
      tick();
      offset_wr_en   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      ad_in = '0;
      offset_wr_en = 1'b0;
      offset_wr_ch = '0;
      offset_wr_data = '0;
      avg_en = 1'b0;
      repeat (2) tick();
      chk("rst_vout", volt_out, 0);
      chk("rst_valid", volt_valid, 0);
      chk("rst_sat", sat_flag, 0);
      rst_n = 1'b1;

      // T1: bypass, zero offsets, latency
      set_in(2048, 4095);
      tick(); tick();
      chk("t1_valid_early", volt_valid, 0);
      tick();
      chk("t1_valid", volt_valid, 1);
      chk("t1_ch0_mid", v0, 0);
      chk("t1_ch1_max", v1, 2047);
      set_in(2048, 0);
      tick(); tick();
      chk("t1_ch1_latency", v1, 2047);
      tick();
      chk("t1_ch1_min", v1, -2048);

      // T2: positive offset with high clip
      wr_off(0, 80);
      set_in(4030, 2048);
      repeat (3) tick();
      chk("t2_ch0_clip", v0, 2047);
      chk("t2_sat_hi", sat_flag, 2'b01);
      chk("t2_ch1_plain", v1, 0);
      set_in(3000, 2048);
      repeat (3) tick();
      chk("t2_ch0_trim", v0, 1032);
      chk("t2_sat_clear", sat_flag, 2'b00);

      // T3: negative offset with low clip
      wr_off(1, 12'hFA2);
      set_in(3000, 50);
      repeat (3) tick();
      chk("t3_ch1_clip", v1, -2048);
      chk("t3_sat_lo", sat_flag, 2'b10);
      chk("t3_ch0_kept", v0, 1032);
      set_in(3000, 2142);
      repeat (3) tick();
      chk("t3_ch1_zero", v1, 0);
      chk("t3_sat_clear", sat_flag, 2'b00);

      // T4: averaging windows of four
      wr_off(0, 0);
      set_in(2048, 2142);
      tick();
      avg_en = 1'b1;
      set_in(2052, 2142);
      tick();
      chk("t4_last_bypass", volt_valid, 1);
      set_in(2056, 2142);
      tick();
      chk("t4_acc_novalid", volt_valid, 0);
      set_in(2060, 2142);
      tick();
      set_in(2047, 2142);
      tick();
      chk("t4_acc_novalid2", volt_valid, 0);
      set_in(2046, 2142);
      tick();
      chk("t4_w1_valid", volt_valid, 1);
      chk("t4_w1_ch0", v0, 6);
      chk("t4_w1_ch1", v1, 0);
      chk("t4_w1_sat", sat_flag, 0);
      tick();
      chk("t4_hold_valid", volt_valid, 0);
      chk("t4_hold_ch0", v0, 6);
      tick(); tick(); tick();
      chk("t4_w2_valid", volt_valid, 1);
      chk("t4_w2_floor", v0, -2);

      // T5: abort partial window, then re-enable
      set_in(2100, 2142);
      tick(); tick();
      chk("t5_partial_novalid", volt_valid, 0);
      avg_en = 1'b0;
      tick();
      chk("t5_drop_novalid", volt_valid, 0);
      chk("t5_drop_hold", v0, -2);
      tick();
      chk("t5_bypass_valid", volt_valid, 1);
      chk("t5_bypass_ch0", v0, 52);
      avg_en = 1'b1;
      tick();
      chk("t5_reen_bypass", volt_valid, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_reen_fill", volt_valid, 0);
      end
      tick();
      chk("t5_reen_valid", volt_valid, 1);
      chk("t5_reen_ch0", v0, 52);

      // T6: async reset mid-window and mid-offset-write
      tick(); tick();
      offset_wr_en = 1'b1;
      offset_wr_ch = 1'b0;
      offset_wr_data = 12'd100;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_vout", volt_out, 0);
      chk("t6_rst_valid", volt_valid, 0);
      chk("t6_rst_sat", sat_flag, 0);
      offset_wr_en = 1'b0;
      avg_en = 1'b0;
      set_in(3000, 50);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("t6_valid_early", volt_valid, 0);
      tick();
      chk("t6_valid", volt_valid, 1);
      chk("t6_ch0_off0", v0, 952);
      chk("t6_ch1_off0", v1, -1998);
      chk("t6_sat", sat_flag, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
